// File: rtl/sdfa_wload_pkg.sv
// Shared types and default geometry for the SDFA weight-memory load controller.
package sdfa_wload_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BYTE_W = 9;
    localparam int unsigned ROW_W  = 8;
    localparam int unsigned BLK_W  = 4;

    localparam int unsigned DEF_NUM_BLK    = 9;
    localparam int unsigned DEF_ROWS       = 256;
    localparam int unsigned DEF_FULL_BYTES = 448;
    localparam int unsigned DEF_LAST_BYTES = 140;
    localparam logic [8:0]  DEF_ZERO_BLK_MASK = 9'b011000000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        STREAM,
        GAP,
        DONE
    } wload_state_e;

endpackage

// File: rtl/sdfa_wload_cnt.sv
// Row/byte position counter with per-block bytes-per-row and last-byte flag.
module sdfa_wload_cnt
    import sdfa_wload_pkg::*;
#(
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned FULL_BYTES = DEF_FULL_BYTES,
    parameter int unsigned LAST_BYTES = DEF_LAST_BYTES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    input  logic             last_blk,
    output logic [ROW_W-1:0] row_idx,
    output logic             last_byte_c
);

    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [BYTE_W-1:0] bpr_m1_c;
    logic              row_end_c;

    // The last block carries a shorter row.
    assign bpr_m1_c    = last_blk ? BYTE_W'(LAST_BYTES - 1) : BYTE_W'(FULL_BYTES - 1);
    assign row_end_c   = (byte_q == bpr_m1_c);
    assign last_byte_c = row_end_c && (row_q == ROW_W'(ROWS - 1));
    assign row_idx     = row_q;

    always_comb begin
        byte_d = byte_q;
        row_d  = row_q;
        if (clr) begin
            byte_d = '0;
            row_d  = '0;
        end else if (inc) begin
            if (row_end_c) begin
                byte_d = '0;
                row_d  = last_byte_c ? '0 : row_q + ROW_W'(1);
            end else begin
                byte_d = byte_q + BYTE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_q <= '0;
            row_q  <= '0;
        end else begin
            byte_q <= byte_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/sdfa_weight_load_ctrl.sv
// Streams source bytes (or internal zero fill) into the SDFA top weight port,
// block by block, honouring the per-block W_REQUEST handshake.
module sdfa_weight_load_ctrl
    import sdfa_wload_pkg::*;
#(
    parameter int unsigned        NUM_BLK       = DEF_NUM_BLK,
    parameter int unsigned        ROWS          = DEF_ROWS,
    parameter int unsigned        FULL_BYTES    = DEF_FULL_BYTES,
    parameter int unsigned        LAST_BYTES    = DEF_LAST_BYTES,
    parameter logic [NUM_BLK-1:0] ZERO_BLK_MASK = NUM_BLK'(DEF_ZERO_BLK_MASK)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              w_request,
    output logic              w_valid,
    output logic [DATA_W-1:0] weight_in,
    output logic [BLK_W-1:0]  blk_idx,
    output logic [ROW_W-1:0]  row_idx,
    output logic              busy,
    output logic              done
);

    wload_state_e      state_q, state_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              w_valid_q, w_valid_d;
    logic [DATA_W-1:0] weight_q, weight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cnt_clr, cnt_inc;
    logic              last_byte_c;
    logic              last_blk_c;
    logic              zero_blk_c;

    always_comb begin
        zero_blk_c = 1'b0;
        for (int unsigned i = 0; i < NUM_BLK; i++) begin
            if (blk_q == BLK_W'(i)) begin
                zero_blk_c = ZERO_BLK_MASK[i];
            end
        end
    end

    assign last_blk_c = (blk_q == BLK_W'(NUM_BLK - 1));
    // Decoded from the state flop, so it drops right after the last byte is taken.
    assign src_ready  = (state_q == STREAM) && !zero_blk_c;

    sdfa_wload_cnt #(
        .ROWS       (ROWS),
        .FULL_BYTES (FULL_BYTES),
        .LAST_BYTES (LAST_BYTES)
    ) u_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (cnt_clr),
        .inc         (cnt_inc),
        .last_blk    (last_blk_c),
        .row_idx     (row_idx),
        .last_byte_c (last_byte_c)
    );

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        w_valid_d = 1'b0;
        weight_d  = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT_REQ;
                    blk_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_REQ: begin
                if (w_request) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (zero_blk_c) begin
                    cnt_inc   = 1'b1;
                    w_valid_d = 1'b1;
                end else if (src_valid) begin
                    cnt_inc   = 1'b1;
                    w_valid_d = 1'b1;
                    weight_d  = src_data;
                end
                if (cnt_inc && last_byte_c) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_clr = 1'b1;
                if (last_blk_c) begin
                    state_d = DONE;
                end else begin
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = WAIT_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            blk_q     <= '0;
            w_valid_q <= 1'b0;
            weight_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            w_valid_q <= w_valid_d;
            weight_q  <= weight_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign w_valid   = w_valid_q;
    assign weight_in = weight_q;
    assign blk_idx   = blk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
